stream_fifo: RTL
================

// Module: stream_fifo
// PURPOSE
//  Parametrised synchronous byte/word FIFO; successor of the fixed 8-bit hyperload FIFO.
//  Sits between CtrlModule producers (tape/disk data strobes) and machine-side consumers.
//  Adds configurable width/depth, a fill level, programmable thresholds and sticky
//  overflow/underflow flags, plus an optional strobe edge-qualifier for slow writers.
// PARAMETERS
//  DATA_WIDTH    8    bits per word
//  ADDRESS_WIDTH 9    log2 of depth; depth = 2**ADDRESS_WIDTH (RAM_SIZE derived)
//  AFULL_LEVEL   448  almost_full asserted when level >= AFULL_LEVEL
//  AEMPTY_LEVEL  64   almost_empty asserted when level <= AEMPTY_LEVEL
//  WRITE_EDGE    1    1: write accepted on rising edge of write; 0: every cycle write is high
// PORTS
//  clk           in   1     single clock (clk50m at top level)
//  reset         in   1     synchronous, active-high; flushes FIFO and flags
//  d             in   DW    write data
//  write         in   1     write request (strobe or level, see WRITE_EDGE)
//  read          in   1     read request, one word per high cycle
//  clear_flags   in   1     clears sticky overflow/underflow
//  q             out  DW    read data
//  empty         out  1     level == 0
//  full          out  1     level == 2**AW
//  almost_empty  out  1     level <= AEMPTY_LEVEL
//  almost_full   out  1     level >= AFULL_LEVEL
//  level         out  AW+1  words stored, 0..2**AW
//  overflow      out  1     sticky: write attempted while full
//  underflow     out  1     sticky: read attempted while empty
// BEHAVIOUR
//  - Reset: wr_ptr=rd_ptr=0, level=0, q=0, empty=1, full=0, almost_empty=1,
//    almost_full=0, overflow=0, underflow=0, edge-detect history reg=0.
//  - Pointers AW+1 bits; wrap modulo 2**AW on address, MSB distinguishes full/empty.
//  - Write accepted (wr_go) when qualified write & !full; qualified write while full
//    is dropped, sets overflow, pointers unchanged.
//  - WRITE_EDGE=1: wr_q = write & ~write_d (write_d registered); a held strobe writes once.
//  - Read accepted (rd_go) when read & !empty; read while empty sets underflow, no change.
//  - Simultaneous wr_go & rd_go: both pointers advance, level unchanged; legal when full
//    only if rd_go (full & read & write: read accepted, write dropped -> overflow set).
//    When empty, write & read: write accepted, read dropped, underflow set.
//  - level/flags registered, updated the cycle after the accepted op; all flags are
//    combinational decodes of registered level.
//  - clear_flags clears sticky bits; same-cycle new error event wins (flag stays 1).
//  - Reset mid-operation discards contents; RAM not cleared, only pointers.
// CONFIGURATION
//  STREAM_FIFO_FWFT_EN defined: first-word-fall-through; q shows head word whenever
//    !empty, read pops it; q valid same cycle as empty deasserts + 1 (RAM latency hidden
//    by an output holding register).
//  undefined: standard mode; q updated one cycle after rd_go, holds otherwise.
// STRUCTURE
//  Shared package stream_fifo_pkg: default DATA_WIDTH/ADDRESS_WIDTH, threshold defaults,
//    level width function clog2-based helper.
//  One sub-module: stream_fifo_ram (simple dual-port, sync write, sync read, DW x 2**AW).
// TESTING
//  1 reset then 3 write edges d=A1,B2,C3, 3 reads -> q=A1,B2,C3 in order, empty=1, level=0.
//  2 fill 512 words (AW=9) -> full=1 at level=512; one more write -> overflow=1, level 512.
//  3 read on empty after reset -> underflow=1, q stays 0; clear_flags -> underflow=0.
//  4 level 448 -> almost_full=1; at 447 ->0; level 64 -> almost_empty=1; 65 ->0.
//  5 write held high 10 cycles with WRITE_EDGE=1 -> level=1; WRITE_EDGE=0 -> level=10.
//  6 full, read+write same cycle -> level 511, overflow=1; reset mid-fill -> level=0, empty=1.

Source files
------------

// File: rtl/stream_fifo_pkg.sv
// Shared defaults and helpers for the stream_fifo block.
package stream_fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH    = 8;
    localparam int unsigned DEFAULT_ADDRESS_WIDTH = 9;
    localparam int unsigned DEFAULT_AFULL_LEVEL   = 448;
    localparam int unsigned DEFAULT_AEMPTY_LEVEL  = 64;

    // Accepted operations this cycle, encoded as {rd_go, wr_go}
    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    // Bits needed to hold a fill level of 0..2**aw inclusive
    function automatic int unsigned level_width(input int unsigned aw);
        return $clog2((1 << aw) + 1);
    endfunction

endpackage

// File: rtl/stream_fifo_if.sv
// Producer/consumer bundle for stream_fifo; master = the side driving d/write/read.
interface stream_fifo_if
    import stream_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) ();

    localparam int unsigned LW = level_width(ADDRESS_WIDTH);

    logic [DATA_WIDTH-1:0] d;
    logic                  write;
    logic                  read;
    logic                  clear_flags;
    logic [DATA_WIDTH-1:0] q;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [LW-1:0]         level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output d, write, read, clear_flags,
        input  q, empty, full, almost_empty, almost_full, level, overflow, underflow
    );

    modport slave (
        input  d, write, read, clear_flags,
        output q, empty, full, almost_empty, almost_full, level, overflow, underflow
    );

endinterface

// File: rtl/stream_fifo_ram.sv
// Simple dual-port storage: synchronous write, synchronous read with resettable output register.
module stream_fifo_ram #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];

    // Contents survive reset; only the read register is cleared
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset)        o_rd_data <= '0;
        else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
    end

endmodule

// File: rtl/stream_fifo.sv
// Parametrised synchronous FIFO with fill level, thresholds and sticky error flags.
// Define STREAM_FIFO_FWFT_EN for first-word-fall-through output; default is standard read.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int unsigned AFULL_LEVEL   = DEFAULT_AFULL_LEVEL,
    parameter int unsigned AEMPTY_LEVEL  = DEFAULT_AEMPTY_LEVEL,
    parameter int unsigned WRITE_EDGE    = 1
) (
    input  logic          clk,
    input  logic          reset,
    stream_fifo_if.slave  bus
);

    localparam int unsigned LW    = level_width(ADDRESS_WIDTH);
    localparam int unsigned PW    = ADDRESS_WIDTH + 1;
    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

    logic [PW-1:0]            r_wr_ptr, r_rd_ptr;
    logic [PW-1:0]            w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [LW-1:0]            r_level, w_level_nxt;
    logic                     r_write_d;
    logic                     r_empty, r_full, r_aempty, r_afull;
    logic                     r_overflow, r_underflow;
    logic                     w_wr_q, w_wr_go, w_rd_go;
    logic                     w_ram_rd_en;
    logic [ADDRESS_WIDTH-1:0] w_ram_rd_addr;
    logic [DATA_WIDTH-1:0]    w_ram_q;
    fifo_op_e                 w_op;

    // Edge qualifier lets slow strobes that stay high for many clocks write once
    assign w_wr_q  = (WRITE_EDGE != 0) ? (bus.write & ~r_write_d) : bus.write;
    assign w_wr_go = w_wr_q & ~r_full;
    assign w_rd_go = bus.read & ~r_empty;
    assign w_op    = fifo_op_e'({w_rd_go, w_wr_go});

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        case (w_op)
            OP_WRITE: w_wr_ptr_nxt = r_wr_ptr + PW'(1);
            OP_READ:  w_rd_ptr_nxt = r_rd_ptr + PW'(1);
            OP_BOTH: begin
                w_wr_ptr_nxt = r_wr_ptr + PW'(1);
                w_rd_ptr_nxt = r_rd_ptr + PW'(1);
            end
            default: ;
        endcase
        w_level_nxt = LW'(w_wr_ptr_nxt - w_rd_ptr_nxt);
    end

    // Flags are decoded from the next level so they line up with the registered level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_write_d   <= 1'b0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_aempty    <= 1'b1;
            r_afull     <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_level     <= w_level_nxt;
            r_write_d   <= bus.write;
            r_empty     <= (w_level_nxt == '0);
            r_full      <= (w_level_nxt == LW'(DEPTH));
            r_aempty    <= (w_level_nxt <= LW'(AEMPTY_LEVEL));
            r_afull     <= (w_level_nxt >= LW'(AFULL_LEVEL));
            r_overflow  <= (w_wr_q & r_full)     | (r_overflow  & ~bus.clear_flags);
            r_underflow <= (bus.read & r_empty)  | (r_underflow & ~bus.clear_flags);
        end
    end

`ifdef STREAM_FIFO_FWFT_EN
    logic                  r_byp_valid;
    logic [DATA_WIDTH-1:0] r_byp_data;

    // Prefetch the next head; a write landing on the prefetched slot is bypassed
    assign w_ram_rd_en   = 1'b1;
    assign w_ram_rd_addr = w_rd_go ? (r_rd_ptr[ADDRESS_WIDTH-1:0] + ADDRESS_WIDTH'(1))
                                   : r_rd_ptr[ADDRESS_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byp_valid <= 1'b0;
            r_byp_data  <= '0;
        end else begin
            r_byp_valid <= w_wr_go & (r_wr_ptr[ADDRESS_WIDTH-1:0] == w_ram_rd_addr);
            r_byp_data  <= bus.d;
        end
    end

    assign bus.q = r_byp_valid ? r_byp_data : w_ram_q;
`else
    assign w_ram_rd_en   = w_rd_go;
    assign w_ram_rd_addr = r_rd_ptr[ADDRESS_WIDTH-1:0];
    assign bus.q         = w_ram_q;
`endif

    stream_fifo_ram #(
        .DW (DATA_WIDTH),
        .AW (ADDRESS_WIDTH)
    ) u_ram (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_go),
        .i_wr_addr (r_wr_ptr[ADDRESS_WIDTH-1:0]),
        .i_wr_data (bus.d),
        .i_rd_en   (w_ram_rd_en),
        .i_rd_addr (w_ram_rd_addr),
        .o_rd_data (w_ram_q)
    );

    assign bus.level        = r_level;
    assign bus.empty        = r_empty;
    assign bus.full         = r_full;
    assign bus.almost_empty = r_aempty;
    assign bus.almost_full  = r_afull;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule
